run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 18 +
 rtl/run_cycle_ctr.sv | 22 ++
 rtl/run_ctrl.sv | 111 +++++++++++
 tb/tb_run_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run_ctrl launch/supervise block.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_e;

  localparam int unsigned START_CYCLES_DEF = 1;
  localparam int unsigned CYC_W_DEF        = 32;
  localparam int unsigned MAX_CYCLES_DEF   = 100000;

  // Start-length counter width; covers the legal START_CYCLES range 1..15.
  localparam int unsigned LAUNCH_W = 4;

endpackage

// File: rtl/run_cycle_ctr.sv
// Clearable, enabled, saturating run-cycle counter used by run_ctrl.
module run_cycle_ctr #(
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Launches one processor run per Go, waits for Ack and reports Done/Cycles.
// Optional watchdog compiled in with macro RUN_CTRL_WATCHDOG_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned START_CYCLES = START_CYCLES_DEF,
  parameter int unsigned CYC_W        = CYC_W_DEF,
  parameter int unsigned MAX_CYCLES   = MAX_CYCLES_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Go,
  output logic             Start,
  input  logic             Ack,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CYC_W-1:0] Cycles
);

  localparam logic [LAUNCH_W-1:0] LAUNCH_LAST = LAUNCH_W'(START_CYCLES - 1);

  state_e              state;
  state_e              next_state;
  logic [LAUNCH_W-1:0] launch_cnt;
  logic [LAUNCH_W-1:0] launch_cnt_next;
  logic                cnt_clr;
  logic                cnt_en;
  logic                wd_hit;

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(MAX_CYCLES - 1);
  // The count reaches MAX_CYCLES on the same edge that leaves RUN.
  assign wd_hit = (Cycles == WD_LAST);
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    next_state      = state;
    launch_cnt_next = launch_cnt;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    unique case (state)
      IDLE: begin
        if (Go) begin
          next_state      = LAUNCH;
          launch_cnt_next = '0;
          cnt_clr         = 1'b1;
        end
      end
      LAUNCH: begin
        if (launch_cnt == LAUNCH_LAST) begin
          next_state = RUN;
        end else begin
          launch_cnt_next = launch_cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (Ack || wd_hit) begin
          next_state = DONE;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      launch_cnt <= '0;
      Start      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= next_state;
      launch_cnt <= launch_cnt_next;
      Start      <= (next_state == LAUNCH);
      Busy       <= (next_state != IDLE);
      Done       <= (next_state == DONE);
    end
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Timeout <= 1'b0;
    end else if ((state == IDLE) && Go) begin
      Timeout <= 1'b0;
    end else if ((state == RUN) && !Ack && wd_hit) begin
      Timeout <= 1'b1;
    end
  end
`else
  assign Timeout = 1'b0;
`endif

  run_cycle_ctr #(
    .CYC_W(CYC_W)
  ) u_cycle_ctr (
    .clk  (Clk),
    .rst_n(Reset_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(Cycles)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl; watchdog cases are built when RUN_CTRL_WATCHDOG_EN is defined.
module tb_run_ctrl;

  logic Clk;
  logic Reset_n;

  logic        go_a, ack_a, start_a, busy_a, done_a, to_a;
  logic [31:0] cyc_a;
  logic        go_b, ack_b, start_b, busy_b, done_b, to_b;
  logic [31:0] cyc_b;
  logic        go_c, ack_c, start_c, busy_c, done_c, to_c;
  logic [3:0]  cyc_c;

  int unsigned total;
  int unsigned bad;
  int unsigned n_start;
  int unsigned n_done;

  run_ctrl #(.START_CYCLES(1)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .Go(go_a), .Start(start_a), .Ack(ack_a),
    .Busy(busy_a), .Done(done_a), .Timeout(to_a), .Cycles(cyc_a)
  );

  run_ctrl #(.START_CYCLES(3)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .Go(go_b), .Start(start_b), .Ack(ack_b),
    .Busy(busy_b), .Done(done_b), .Timeout(to_b), .Cycles(cyc_b)
  );

  run_ctrl #(.START_CYCLES(1), .CYC_W(4), .MAX_CYCLES(12)) u_c (
    .Clk(Clk), .Reset_n(Reset_n), .Go(go_c), .Start(start_c), .Ack(ack_c),
    .Busy(busy_c), .Done(done_c), .Timeout(to_c), .Cycles(cyc_c)
  );

`ifdef RUN_CTRL_WATCHDOG_EN
  logic        go_w, ack_w, start_w, busy_w, done_w, to_w;
  logic [31:0] cyc_w;

  run_ctrl #(.START_CYCLES(1), .MAX_CYCLES(10)) u_w (
    .Clk(Clk), .Reset_n(Reset_n), .Go(go_w), .Start(start_w), .Ack(ack_w),
    .Busy(busy_w), .Done(done_w), .Timeout(to_w), .Cycles(cyc_w)
  );
`endif

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    Reset_n = 1'b0;
    go_a = 0; ack_a = 0; go_b = 0; ack_b = 0; go_c = 0; ack_c = 0;
`ifdef RUN_CTRL_WATCHDOG_EN
    go_w = 0; ack_w = 0;
`endif
    #12;
    check("rst_start", start_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_to",    to_a, 0);
    check("rst_cyc",   cyc_a, 0);
    Reset_n = 1'b1;

    // Basic run: Ack raised in RUN cycle 5.
    go_a = 1; step(); go_a = 0;
    check("a_launch_start", start_a, 1);
    check("a_launch_busy",  busy_a, 1);
    check("a_launch_cyc",   cyc_a, 0);
    n_start = start_a; n_done = done_a;
    for (int i = 1; i <= 5; i++) begin
      step(); n_start += start_a; n_done += done_a;
    end
    check("a_run5_cyc", cyc_a, 4);
    ack_a = 1; step(); ack_a = 0;
    n_start += start_a; n_done += done_a;
    check("a_done",      done_a, 1);
    check("a_done_cyc",  cyc_a, 5);
    check("a_done_to",   to_a, 0);
    check("a_done_busy", busy_a, 1);
    step(); n_done += done_a;
    check("a_idle_busy", busy_a, 0);
    check("a_idle_cyc",  cyc_a, 5);
    check("a_n_start",   n_start, 1);
    check("a_n_done",    n_done, 1);

    // START_CYCLES=3 with Ack held high from launch onward.
    ack_b = 1; go_b = 1; step(); go_b = 0;
    n_start = start_b;
    step(); n_start += start_b;
    step(); n_start += start_b;
    step(); n_start += start_b;
    check("b_n_start",   n_start, 3);
    check("b_run1_busy", busy_b, 1);
    check("b_run1_done", done_b, 0);
    check("b_run1_cyc",  cyc_b, 0);
    step();
    check("b_done",     done_b, 1);
    check("b_done_cyc", cyc_b, 1);
    ack_b = 0; step();
    check("b_idle_busy", busy_b, 0);

    // Asynchronous reset in RUN cycle 4, Go accepted at the release edge.
    go_a = 1; step(); go_a = 0;
    for (int i = 1; i <= 4; i++) step();
    check("r_run4_cyc", cyc_a, 3);
    #2 Reset_n = 1'b0;
    #1;
    check("r_async_busy",  busy_a, 0);
    check("r_async_start", start_a, 0);
    check("r_async_done",  done_a, 0);
    check("r_async_to",    to_a, 0);
    check("r_async_cyc",   cyc_a, 0);
    Reset_n = 1'b1; go_a = 1; step(); go_a = 0;
    check("r_relaunch_start", start_a, 1);
    check("r_relaunch_cyc",   cyc_a, 0);
    step(); step(); step();
    ack_a = 1; step(); ack_a = 0;
    check("r_done",     done_a, 1);
    check("r_done_cyc", cyc_a, 3);
    step();

    // Go during RUN and during DONE must not start another run.
    go_a = 1; step(); go_a = 0;
    n_done = 0;
    step();
    go_a = 1; step(); go_a = 0; n_done += done_a;
    step(); n_done += done_a;
    ack_a = 1; step(); ack_a = 0; n_done += done_a;
    check("g_done_cyc", cyc_a, 3);
    go_a = 1; step(); go_a = 0; n_done += done_a;
    check("g_after_busy", busy_a, 0);
    step(); n_done += done_a;
    check("g_idle_busy",  busy_a, 0);
    check("g_idle_start", start_a, 0);
    check("g_idle_cyc",   cyc_a, 3);
    check("g_n_done",     n_done, 1);

    // Narrow counter: saturation (or watchdog at 12 when compiled in).
    go_c = 1; step(); go_c = 0; step();
    for (int i = 2; i <= 20 && !done_c; i++) step();
`ifdef RUN_CTRL_WATCHDOG_EN
    check("c_wd_done", done_c, 1);
    check("c_wd_cyc",  cyc_c, 12);
    check("c_wd_to",   to_c, 1);
`else
    check("c_sat_pre_cyc",  cyc_c, 15);
    check("c_sat_pre_done", done_c, 0);
    ack_c = 1; step(); ack_c = 0;
    check("c_sat_done", done_c, 1);
    check("c_sat_cyc",  cyc_c, 15);
    check("c_sat_to",   to_c, 0);
`endif
    step();
    check("c_idle_busy", busy_c, 0);

`ifdef RUN_CTRL_WATCHDOG_EN
    // Watchdog at 10 RUN cycles, then Ack on the limit cycle takes priority.
    go_w = 1; step(); go_w = 0; step();
    for (int i = 2; i <= 40 && !done_w; i++) step();
    check("w_done", done_w, 1);
    check("w_cyc",  cyc_w, 10);
    check("w_to",   to_w, 1);
    step();
    check("w_hold_to",   to_w, 1);
    check("w_hold_busy", busy_w, 0);
    go_w = 1; step(); go_w = 0;
    check("w_relaunch_to",  to_w, 0);
    check("w_relaunch_cyc", cyc_w, 0);
    for (int i = 1; i <= 10; i++) step();
    ack_w = 1; step(); ack_w = 0;
    check("w_prio_done", done_w, 1);
    check("w_prio_cyc",  cyc_w, 10);
    check("w_prio_to",   to_w, 0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
